// File: rtl/nvdla_sdp_rdma_unpack_gen.sv
// Atom packer for the SDP RDMA return path: merges masked input beats into OUT_ATOMS-wide words.
// Optional perf counters are built when NVDLA_SDP_UNPACK_PERF_EN is defined.
module nvdla_sdp_rdma_unpack_gen #(
  parameter int ATOM_DW   = 64,
  parameter int IN_ATOMS  = 2,
  parameter int OUT_ATOMS = 4,
  parameter int CNT_W     = $clog2(OUT_ATOMS + 1)
) (
  input  logic                                   nvdla_core_clk,
  input  logic                                   nvdla_core_rstn,
  input  logic                                   inp_pvld,
  output logic                                   inp_prdy,
  input  logic [IN_ATOMS*ATOM_DW+IN_ATOMS-1:0]   inp_data,
  input  logic                                   inp_end,
  output logic                                   out_pvld,
  input  logic                                   out_prdy,
  output logic [OUT_ATOMS*ATOM_DW+OUT_ATOMS-1:0] out_data,
  output logic                                   out_end,
  output logic [31:0]                            perf_word_cnt,
  output logic [31:0]                            perf_part_cnt
);

  localparam int SW = CNT_W + 1;
  localparam int MW = OUT_ATOMS + IN_ATOMS;
  localparam logic [SW-1:0] OUT_N = SW'(OUT_ATOMS);

  typedef enum logic {ST_ACC, ST_FLUSH} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     sz;
  logic [SW-1:0]        sum;
  logic [SW-1:0]        spill;
  logic [SW-1:0]        fill;
  logic                 has_spill;
  logic                 complete;
  logic                 out_free;
  logic                 inp_fire;
  logic                 out_fire;
  logic [IN_ATOMS-1:0]  inp_mask;
  logic [ATOM_DW-1:0]   beat      [IN_ATOMS];
  logic [ATOM_DW-1:0]   acc       [OUT_ATOMS];
  logic [ATOM_DW-1:0]   merged    [MW];
  logic [ATOM_DW-1:0]   out_atoms [OUT_ATOMS];
  logic [OUT_ATOMS-1:0] out_mask;

  function automatic logic [OUT_ATOMS-1:0] therm(input logic [SW-1:0] n);
    logic [OUT_ATOMS-1:0] m;
    for (int i = 0; i < OUT_ATOMS; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  assign out_free = !out_pvld || out_prdy;
  assign inp_prdy = (state == ST_ACC) && out_free;
  assign inp_fire = inp_pvld && inp_prdy;
  assign out_fire = out_pvld && out_prdy;

  // The beat always contributes its lowest sz slots, regardless of which mask bits are set.
  always_comb begin
    inp_mask = inp_data[IN_ATOMS*ATOM_DW +: IN_ATOMS];
    sz = '0;
    for (int i = 0; i < IN_ATOMS; i++) begin
      beat[i] = inp_data[i*ATOM_DW +: ATOM_DW];
      sz = sz + CNT_W'(inp_mask[i]);
    end
  end

  always_comb begin
    sum       = {1'b0, cnt} + {1'b0, sz};
    has_spill = (sum > OUT_N);
    spill     = has_spill ? (sum - OUT_N) : '0;
    fill      = has_spill ? OUT_N : sum;
    complete  = (sum >= OUT_N) || inp_end;
  end

  // Accumulator followed by the beat atoms at slot cnt; slots past OUT_ATOMS are the spill.
  always_comb begin
    for (int j = 0; j < OUT_ATOMS; j++) merged[j] = acc[j];
    for (int j = OUT_ATOMS; j < MW; j++) merged[j] = '0;
    for (int j = 0; j < MW; j++) begin
      for (int k = 0; k < IN_ATOMS; k++) begin
        if ((k < int'(sz)) && (j == int'(cnt) + k)) merged[j] = beat[k];
      end
    end
  end

  // NOTE: acc is pure datapath gated by cnt, so it carries no reset; clearing cnt discards it.
  always_ff @(posedge nvdla_core_clk) begin
    if (inp_fire) begin
      if (complete) begin
        for (int j = 0; j < IN_ATOMS; j++) acc[j] <= merged[OUT_ATOMS+j];
      end else begin
        for (int j = 0; j < OUT_ATOMS; j++) acc[j] <= merged[j];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state    <= ST_ACC;
      cnt      <= '0;
      out_pvld <= 1'b0;
      out_end  <= 1'b0;
      out_mask <= '0;
      for (int j = 0; j < OUT_ATOMS; j++) out_atoms[j] <= '0;
    end else begin
      if (out_fire) out_pvld <= 1'b0;
      case (state)
        ST_ACC: begin
          if (inp_fire) begin
            if (complete) begin
              out_pvld <= 1'b1;
              out_mask <= therm(fill);
              out_end  <= inp_end && !has_spill;
              for (int j = 0; j < OUT_ATOMS; j++) out_atoms[j] <= merged[j];
              cnt      <= spill[CNT_W-1:0];
              if (inp_end && has_spill) state <= ST_FLUSH;
            end else begin
              cnt <= sum[CNT_W-1:0];
            end
          end
        end
        ST_FLUSH: begin
          // The spill of an ending beat already sits in acc slots 0..cnt-1.
          if (out_free) begin
            out_pvld <= 1'b1;
            out_mask <= therm({1'b0, cnt});
            out_end  <= 1'b1;
            for (int j = 0; j < OUT_ATOMS; j++) out_atoms[j] <= acc[j];
            cnt      <= '0;
            state    <= ST_ACC;
          end
        end
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    out_data[OUT_ATOMS*ATOM_DW +: OUT_ATOMS] = out_mask;
    for (int j = 0; j < OUT_ATOMS; j++) out_data[j*ATOM_DW +: ATOM_DW] = out_atoms[j];
  end

`ifdef NVDLA_SDP_UNPACK_PERF_EN
  logic [31:0] word_cnt;
  logic [31:0] part_cnt;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      word_cnt <= '0;
      part_cnt <= '0;
    end else if (out_fire) begin
      if (word_cnt != '1) word_cnt <= word_cnt + 32'd1;
      if ((out_mask != '1) && (part_cnt != '1)) part_cnt <= part_cnt + 32'd1;
    end
  end

  assign perf_word_cnt = word_cnt;
  assign perf_part_cnt = part_cnt;
`else
  assign perf_word_cnt = '0;
  assign perf_part_cnt = '0;
`endif

endmodule
